execute_unit: RTL and testbench
===============================

Name: execute_unit

Overview:
- Parametrised execute stage of the Lua processor pipeline; sits between decode and write-back/memory.
- Accepts one decoded Lua 5.1 instruction per handshake with operand values already read.
- Produces a register write-back, an optional memory store request and a PC-relative branch.
- Adds a valid/ready handshake, a multi-cycle multiplier, branch resolution and illegal-opcode flagging.

Parameters:
- DATA_W, 32, width of register/memory data and addresses.
- REG_ID_W, 8, width of register index (operandA).
- MUL_STEP, 1, multiplier bits retired per cycle; must divide DATA_W; MUL latency = DATA_W/MUL_STEP cycles.

Ports:
- clk_ex  in  1  stage clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- opecode  in  8  opcode; only [5:0] decoded.
- operandA  in  REG_ID_W  destination register / store base index.
- operandB  in  24  B field; sBx for JMP (two's complement, 24-bit).
- operandC  in  16  C field; low bit is the compare sense k for EQ/LT.
- src_b  in  DATA_W  value of RK(B).
- src_c  in  DATA_W  value of RK(C).
- reg_we  out  1  one-cycle write-back strobe.
- reg_id  out  REG_ID_W  write-back destination.
- reg_val  out  DATA_W  write-back value.
- mem_valid  out  1  store request valid.
- mem_ready  in  1  memory accepts the store.
- mem_addr  out  DATA_W  store address.
- mem_val  out  DATA_W  store data.
- br_taken  out  1  one-cycle strobe: PC += br_off.
- br_off  out  DATA_W  sign-extended branch offset.
- illegal  out  1  one-cycle strobe on undefined opcode.

Behaviour:
- Reset, synchronous: all outputs 0; state IDLE. Any in-flight MUL or store is abandoned.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0; runs shift-add.
  - STORE: in_ready=0; mem_valid=1 and mem_addr/mem_val held stable until mem_ready.
- Every accepted instruction drives its result strobes for exactly one cycle, in the cycle after completion. All strobes default to 0.
- Opcode set (opecode[5:0]):
  - 0 MOVE: reg_val=src_b.
  - 1 LOADK: reg_val=src_b, the constant.
  - 12 ADD: reg_val=src_b+src_c, wrap modulo 2^DATA_W.
  - 13 SUB: reg_val=src_b-src_c, wrap modulo 2^DATA_W.
  - 14 MUL: low DATA_W bits of the product.
  - 18 UNM: reg_val=0-src_b.
  - 22 JMP: br_off=sign-extend(operandB).
  - 23 EQ / 24 LT: signed compare; if (cmp != operandC[0]), br_taken=1 with br_off=1 (skip next instruction).
  - 9 SETTABLE-store: mem_addr=src_b, mem_val=src_c; enter STORE.
  - Anything else: illegal=1, no other effect.
- reg_id = operandA for every write-back op.
- Latency:
  - Single-cycle ops: result strobes 1 cycle after accept; back-to-back accept every cycle.
  - MUL: reg_we fires DATA_W/MUL_STEP cycles after accept; returns to IDLE the same cycle.
  - STORE: leaves the state the cycle mem_ready is seen; no reg_we. mem_ready already high on the first STORE cycle gives a 1-cycle store. in_ready returns the next cycle.
- in_valid while in_ready=0 is ignored; decode must hold the instruction.
- MUL with src_b or src_c zero still takes full latency (fixed timing).

Optional Feature:
- EXEC_MUL_EN:
  - Defined: MUL implemented as above.
  - Undefined: no multiplier or MUL state is built; opcode 14 raises illegal=1 in 1 cycle with no reg_we.

Test Plan:
- Reset mid-MUL (src_b=7, src_c=9, reset after 3 cycles) -> next cycle all outputs 0, in_ready=1, no reg_we ever for that MUL.
- ADD A=5, src_b=0xFFFFFFFF, src_c=2 -> one cycle later reg_we=1, reg_id=5, reg_val=0x00000001; back-to-back SUB src_b=3, src_c=5 the next cycle -> reg_val=0xFFFFFFFE.
- MUL src_b=123, src_c=1000, MUL_STEP=1 -> in_ready=0 for 32 cycles, then reg_val=123000; a concurrently held ADD is accepted only after that.
- STORE src_b=567, src_c=999, mem_ready low 4 cycles then high -> mem_valid=1 with stable addr/val for 5 cycles, then 0; in_ready=1 next cycle.
- JMP operandB=0xFFFFFD -> br_taken=1, br_off=0xFFFFFFFD. LT src_b=-1, src_c=2, operandC[0]=0 -> br_taken=1, br_off=1.
- opecode 0x3F -> illegal=1 for one cycle, reg_we=0, mem_valid=0. With EXEC_MUL_EN undefined, opcode 14 -> illegal=1.

Source files
------------

// File: rtl/execute_unit.sv
// execute_unit: execute stage of the Lua processor pipeline.
// Takes one decoded Lua 5.1 instruction per valid/ready handshake. It produces
// a one-cycle register write-back, a held memory store request, or a
// PC-relative branch strobe. Undefined opcodes raise a one-cycle illegal strobe.
// Build option EXEC_MUL_EN: when defined, opcode 14 (MUL) uses a shift-add
// multiplier that retires MUL_STEP bits per cycle. When undefined, no
// multiplier or MUL state is built, and opcode 14 is flagged illegal.
module execute_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 8,
    parameter int MUL_STEP = 1
) (
    input  logic                clk_ex,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          opecode,
    input  logic [REG_ID_W-1:0] operandA,
    input  logic [23:0]         operandB,
    input  logic [15:0]         operandC,
    input  logic [DATA_W-1:0]   src_b,
    input  logic [DATA_W-1:0]   src_c,
    output logic                reg_we,
    output logic [REG_ID_W-1:0] reg_id,
    output logic [DATA_W-1:0]   reg_val,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_val,
    output logic                br_taken,
    output logic [DATA_W-1:0]   br_off,
    output logic                illegal
);

    // Opcode numbers (low six bits of opecode)
    localparam logic [5:0] OP_MOVE  = 6'd0;
    localparam logic [5:0] OP_LOADK = 6'd1;
    localparam logic [5:0] OP_STORE = 6'd9;
    localparam logic [5:0] OP_ADD   = 6'd12;
    localparam logic [5:0] OP_SUB   = 6'd13;
    localparam logic [5:0] OP_MUL   = 6'd14;
    localparam logic [5:0] OP_UNM   = 6'd18;
    localparam logic [5:0] OP_JMP   = 6'd22;
    localparam logic [5:0] OP_EQ    = 6'd23;
    localparam logic [5:0] OP_LT    = 6'd24;

    // Multiply latency in cycles; MUL_STEP must divide DATA_W
    localparam int MUL_CYCLES = DATA_W / MUL_STEP;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef EXEC_MUL_EN
        ST_MUL   = 2'd1,
`endif
        ST_STORE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Sign-extend the 24-bit sBx field to a full-width branch offset
    function automatic logic [DATA_W-1:0] sext_off(input logic [23:0] b);
        logic signed [23:0] b_s;
        b_s = b;
        return DATA_W'(b_s);
    endfunction

    // Two's-complement compare used by LT
    function automatic logic signed_lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        a_s = a;
        b_s = b;
        return a_s < b_s;
    endfunction

    logic       w_accept;
    logic [5:0] w_op;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_op     = opecode[5:0];

    // Decode-stage results (p0), valid only when w_accept is high
    logic              w_dec_we_p0;
    logic [DATA_W-1:0] w_dec_val_p0;
    logic              w_dec_br_p0;
    logic [DATA_W-1:0] w_dec_off_p0;
    logic              w_dec_ill_p0;
    logic              w_dec_store_p0;
    logic              w_dec_mul_p0;

    // Decode the opcode and compute single-cycle results
    always_comb begin
        w_dec_we_p0    = 1'b0;
        w_dec_val_p0   = '0;
        w_dec_br_p0    = 1'b0;
        w_dec_off_p0   = '0;
        w_dec_ill_p0   = 1'b0;
        w_dec_store_p0 = 1'b0;
        w_dec_mul_p0   = 1'b0;
        case (w_op)
            OP_MOVE, OP_LOADK: begin
                w_dec_we_p0  = 1'b1;
                w_dec_val_p0 = src_b;
            end
            OP_ADD: begin
                w_dec_we_p0  = 1'b1;
                w_dec_val_p0 = src_b + src_c;
            end
            OP_SUB: begin
                w_dec_we_p0  = 1'b1;
                w_dec_val_p0 = src_b - src_c;
            end
            OP_UNM: begin
                w_dec_we_p0  = 1'b1;
                w_dec_val_p0 = '0 - src_b;
            end
            OP_JMP: begin
                w_dec_br_p0  = 1'b1;
                w_dec_off_p0 = sext_off(operandB);
            end
            OP_EQ: begin
                // Skip the next instruction when the comparison disagrees with k
                if ((src_b == src_c) != operandC[0]) begin
                    w_dec_br_p0  = 1'b1;
                    w_dec_off_p0 = DATA_W'(1);
                end
            end
            OP_LT: begin
                if (signed_lt(src_b, src_c) != operandC[0]) begin
                    w_dec_br_p0  = 1'b1;
                    w_dec_off_p0 = DATA_W'(1);
                end
            end
            OP_STORE: begin
                w_dec_store_p0 = 1'b1;
            end
`ifdef EXEC_MUL_EN
            OP_MUL: begin
                w_dec_mul_p0 = 1'b1;
            end
`endif
            default: begin
                w_dec_ill_p0 = 1'b1;
            end
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [REG_ID_W-1:0] r_mul_id;
    logic [DATA_W-1:0]   w_partial;
    logic [DATA_W-1:0]   w_acc_next;
    logic                w_mul_active;
    logic                w_mul_last;

    assign w_mul_active = (r_state == ST_MUL);
    assign w_mul_last   = w_mul_active && (r_cnt == CNT_W'(MUL_CYCLES - 1));
    assign w_acc_next   = r_acc + w_partial;

    // Partial product for the MUL_STEP multiplier bits retired this cycle
    always_comb begin
        w_partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (r_mplier[i]) begin
                w_partial = w_partial + (r_mcand << i);
            end
        end
    end

    // Step counter; runs the full count even for zero operands
    always_ff @(posedge clk_ex) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept && w_dec_mul_p0) begin
            r_cnt <= '0;
        end else if (w_mul_active) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Shift-add datapath: multiplicand moves left, multiplier moves right
    always_ff @(posedge clk_ex) begin
        if (w_accept && w_dec_mul_p0) begin
            r_acc    <= '0;
            r_mcand  <= src_b;
            r_mplier <= src_c;
            r_mul_id <= operandA;
        end else if (w_mul_active) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << MUL_STEP;
            r_mplier <= r_mplier >> MUL_STEP;
        end
    end
`endif

    // State register
    always_ff @(posedge clk_ex) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_dec_store_p0) begin
                    w_state_next = ST_STORE;
                end
`ifdef EXEC_MUL_EN
                if (w_accept && w_dec_mul_p0) begin
                    w_state_next = ST_MUL;
                end
`endif
            end
`ifdef EXEC_MUL_EN
            ST_MUL: begin
                if (w_mul_last) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            ST_STORE: begin
                if (mem_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Result stage (p1) registers
    logic                r_reg_we_p1;
    logic [REG_ID_W-1:0] r_reg_id_p1;
    logic [DATA_W-1:0]   r_reg_val_p1;
    logic                r_br_taken_p1;
    logic [DATA_W-1:0]   r_br_off_p1;
    logic                r_illegal_p1;

    // Result strobes: cleared every cycle, set for one cycle after completion
    always_ff @(posedge clk_ex) begin
        if (reset) begin
            r_reg_we_p1   <= 1'b0;
            r_reg_id_p1   <= '0;
            r_reg_val_p1  <= '0;
            r_br_taken_p1 <= 1'b0;
            r_br_off_p1   <= '0;
            r_illegal_p1  <= 1'b0;
        end else begin
            r_reg_we_p1   <= 1'b0;
            r_reg_id_p1   <= '0;
            r_reg_val_p1  <= '0;
            r_br_taken_p1 <= 1'b0;
            r_br_off_p1   <= '0;
            r_illegal_p1  <= 1'b0;
            if (w_accept) begin
                r_reg_we_p1   <= w_dec_we_p0;
                r_reg_id_p1   <= w_dec_we_p0 ? operandA : '0;
                r_reg_val_p1  <= w_dec_val_p0;
                r_br_taken_p1 <= w_dec_br_p0;
                r_br_off_p1   <= w_dec_off_p0;
                r_illegal_p1  <= w_dec_ill_p0;
            end
`ifdef EXEC_MUL_EN
            if (w_mul_last) begin
                r_reg_we_p1  <= 1'b1;
                r_reg_id_p1  <= r_mul_id;
                r_reg_val_p1 <= w_acc_next;
            end
`endif
        end
    end

    logic              r_mem_valid;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_val;

    // Store request: address and data held stable until memory accepts
    always_ff @(posedge clk_ex) begin
        if (reset) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_val   <= '0;
        end else if (w_accept && w_dec_store_p0) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= src_b;
            r_mem_val   <= src_c;
        end else if (r_mem_valid && mem_ready) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_val   <= '0;
        end
    end

    assign reg_we    = r_reg_we_p1;
    assign reg_id    = r_reg_id_p1;
    assign reg_val   = r_reg_val_p1;
    assign br_taken  = r_br_taken_p1;
    assign br_off    = r_br_off_p1;
    assign illegal   = r_illegal_p1;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_val   = r_mem_val;

    // Opcode bits 7:6 and C bits 15:1 carry no meaning in this stage
    logic w_unused;
    assign w_unused = &{1'b0, opecode[7:6], operandC[15:1], (MUL_CYCLES != 0)};

endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: self-checking bench for execute_unit with directed and
// randomized stimulus compared against a behavioural instruction model.
module tb_execute_unit;

    localparam int DATA_W   = 32;
    localparam int REG_ID_W = 8;
    localparam int MUL_STEP = 1;

    logic                clk_ex = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          opecode;
    logic [REG_ID_W-1:0] operandA;
    logic [23:0]         operandB;
    logic [15:0]         operandC;
    logic [DATA_W-1:0]   src_b;
    logic [DATA_W-1:0]   src_c;
    logic                reg_we;
    logic [REG_ID_W-1:0] reg_id;
    logic [DATA_W-1:0]   reg_val;
    logic                mem_valid;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_val;
    logic                br_taken;
    logic [DATA_W-1:0]   br_off;
    logic                illegal;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        we;
        logic [7:0]  id;
        logic [31:0] val;
        logic        br;
        logic [31:0] off;
        logic        ill;
        logic        st;
    } exp_t;

    execute_unit #(.DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .MUL_STEP(MUL_STEP)) dut (
        .clk_ex(clk_ex), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opecode(opecode), .operandA(operandA), .operandB(operandB), .operandC(operandC),
        .src_b(src_b), .src_c(src_c), .reg_we(reg_we), .reg_id(reg_id), .reg_val(reg_val),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_val(mem_val),
        .br_taken(br_taken), .br_off(br_off), .illegal(illegal)
    );

    always #5 clk_ex = ~clk_ex;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Instruction semantics from the opcode table, using 64-bit arithmetic
    function automatic exp_t model(input logic [7:0] op, input logic [7:0] a, input logic [23:0] b,
                                   input logic [15:0] c, input logic [31:0] sb, input logic [31:0] sc);
        exp_t e;
        longint unsigned m;
        longint unsigned ub;
        longint unsigned uc;
        longint sb_s;
        longint sc_s;
        bit cmp;
        m  = 64'h1_0000_0000;
        ub = longint'(sb);
        uc = longint'(sc);
        sb_s = (ub >= 64'h8000_0000) ? longint'(ub) - longint'(m) : longint'(ub);
        sc_s = (uc >= 64'h8000_0000) ? longint'(uc) - longint'(m) : longint'(uc);
        e = '0;
        case (int'(op % 8'd64))
            0, 1:  begin e.we = 1'b1; e.id = a; e.val = sb; end
            12:    begin e.we = 1'b1; e.id = a; e.val = 32'((ub + uc) % m); end
            13:    begin e.we = 1'b1; e.id = a; e.val = 32'((ub + m - uc) % m); end
`ifdef EXEC_MUL_EN
            14:    begin e.we = 1'b1; e.id = a; e.val = 32'((ub * uc) % m); end
`endif
            18:    begin e.we = 1'b1; e.id = a; e.val = 32'((m - ub) % m); end
            22:    begin
                       e.br = 1'b1;
                       e.off = (b >= 24'h800000) ? 32'(longint'(b) + longint'(m) - 64'h100_0000) : 32'(b);
                   end
            23:    begin cmp = (ub == uc); if (cmp != c[0]) begin e.br = 1'b1; e.off = 32'd1; end end
            24:    begin cmp = (sb_s < sc_s); if (cmp != c[0]) begin e.br = 1'b1; e.off = 32'd1; end end
            9:     e.st = 1'b1;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [139:0] outs();
        return {reg_we, reg_id, reg_val, mem_valid, mem_addr, mem_val, br_taken, br_off, illegal};
    endfunction

    task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic [23:0] b,
                         input logic [15:0] c, input logic [31:0] sb, input logic [31:0] sc);
        in_valid = 1'b1;
        opecode  = op;
        operandA = a;
        operandB = b;
        operandC = c;
        src_b    = sb;
        src_c    = sc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk_ex);
        n_checks++;
        if (outs() !== '0) $display("FAIL reset_outputs: got %h want 0", outs());
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_reset_midop();
        bit seen;
`ifdef EXEC_MUL_EN
        @(negedge clk_ex); drive(8'd14, 8'd4, 24'd0, 16'd0, 32'd7, 32'd9);
        @(negedge clk_ex); in_valid = 1'b0;
        repeat (2) @(negedge clk_ex);
`else
        @(negedge clk_ex); mem_ready = 1'b0; drive(8'd9, 8'd4, 24'd0, 16'd0, 32'd7, 32'd9);
        @(negedge clk_ex); in_valid = 1'b0;
        n_checks++;
        if (mem_valid !== 1'b1) $display("FAIL midop_store_started: got %b want 1", mem_valid);
        else n_pass++;
        repeat (2) @(negedge clk_ex);
`endif
        reset = 1'b1;
        @(negedge clk_ex);
        n_checks++;
        if ({outs(), in_ready} !== {140'd0, 1'b1})
            $display("FAIL midop_reset: got outs=%h in_ready=%b want 0/1", outs(), in_ready);
        else n_pass++;
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_ex);
            if (reg_we || mem_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midop_abandoned: got late activity=%b want 0", seen);
        else n_pass++;
    endtask

    task automatic test_add_sub();
        @(negedge clk_ex); drive(8'd12, 8'd5, 24'd0, 16'd0, 32'hFFFFFFFF, 32'd2);
        @(negedge clk_ex);
        n_checks++;
        if ({reg_we, reg_id, reg_val} !== {1'b1, 8'd5, 32'h00000001})
            $display("FAIL add_wrap: got we=%b id=%0d val=%h want 1/5/00000001", reg_we, reg_id, reg_val);
        else n_pass++;
        drive(8'd13, 8'd6, 24'd0, 16'd0, 32'd3, 32'd5);
        @(negedge clk_ex);
        n_checks++;
        if ({reg_we, reg_id, reg_val} !== {1'b1, 8'd6, 32'hFFFFFFFE})
            $display("FAIL sub_b2b: got we=%b id=%0d val=%h want 1/6/fffffffe", reg_we, reg_id, reg_val);
        else n_pass++;
        in_valid = 1'b0;
        @(negedge clk_ex);
        n_checks++;
        if ({reg_we, reg_id, reg_val} !== 41'd0)
            $display("FAIL strobe_one_cycle: got we=%b id=%0d val=%h want 0", reg_we, reg_id, reg_val);
        else n_pass++;
    endtask

    task automatic test_branch();
        @(negedge clk_ex); drive(8'd22, 8'd0, 24'hFFFFFD, 16'd0, 32'd0, 32'd0);
        @(negedge clk_ex);
        n_checks++;
        if ({br_taken, br_off, reg_we} !== {1'b1, 32'hFFFFFFFD, 1'b0})
            $display("FAIL jmp: got br=%b off=%h we=%b want 1/fffffffd/0", br_taken, br_off, reg_we);
        else n_pass++;
        drive(8'd24, 8'd0, 24'd0, 16'd0, 32'hFFFFFFFF, 32'd2);
        @(negedge clk_ex);
        n_checks++;
        if ({br_taken, br_off} !== {1'b1, 32'd1})
            $display("FAIL lt_skip: got br=%b off=%h want 1/00000001", br_taken, br_off);
        else n_pass++;
        drive(8'd23, 8'd0, 24'd0, 16'd1, 32'd5, 32'd5);
        @(negedge clk_ex);
        n_checks++;
        if ({br_taken, br_off} !== {1'b0, 32'd0})
            $display("FAIL eq_noskip: got br=%b off=%h want 0/00000000", br_taken, br_off);
        else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        @(negedge clk_ex); drive(8'h3F, 8'd2, 24'd0, 16'd0, 32'd1, 32'd1);
        @(negedge clk_ex); in_valid = 1'b0;
        n_checks++;
        if ({illegal, reg_we, mem_valid, br_taken, in_ready} !== 5'b10001)
            $display("FAIL illegal_3f: got ill=%b we=%b mv=%b br=%b rdy=%b want 1/0/0/0/1",
                     illegal, reg_we, mem_valid, br_taken, in_ready);
        else n_pass++;
        @(negedge clk_ex);
        n_checks++;
        if (illegal !== 1'b0) $display("FAIL illegal_one_cycle: got %b want 0", illegal);
        else n_pass++;
`ifndef EXEC_MUL_EN
        drive(8'd14, 8'd2, 24'd0, 16'd0, 32'd3, 32'd4);
        @(negedge clk_ex); in_valid = 1'b0;
        n_checks++;
        if ({illegal, reg_we, in_ready} !== 3'b101)
            $display("FAIL mul_disabled: got ill=%b we=%b rdy=%b want 1/0/1", illegal, reg_we, in_ready);
        else n_pass++;
`endif
    endtask

    task automatic test_store();
        int lat;
        logic [31:0] a_exp;
        logic [31:0] v_exp;
        @(negedge clk_ex); mem_ready = 1'b0; drive(8'd9, 8'd1, 24'd0, 16'd0, 32'd567, 32'd999);
        @(negedge clk_ex); drive(8'd12, 8'd7, 24'd0, 16'd0, 32'd10, 32'd20);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk_ex);
            mem_ready = (k == 4);
            n_checks++;
            if ({mem_valid, mem_addr, mem_val, in_ready, reg_we} !== {1'b1, 32'd567, 32'd999, 1'b0, 1'b0})
                $display("FAIL store_hold[%0d]: got mv=%b addr=%0d val=%0d rdy=%b we=%b want 1/567/999/0/0",
                         k, mem_valid, mem_addr, mem_val, in_ready, reg_we);
            else n_pass++;
        end
        @(negedge clk_ex); mem_ready = 1'b0;
        n_checks++;
        if ({mem_valid, in_ready, reg_we} !== 3'b010)
            $display("FAIL store_done: got mv=%b rdy=%b we=%b want 0/1/0", mem_valid, in_ready, reg_we);
        else n_pass++;
        @(negedge clk_ex); in_valid = 1'b0;
        n_checks++;
        if ({reg_we, reg_id, reg_val} !== {1'b1, 8'd7, 32'd30})
            $display("FAIL held_after_store: got we=%b id=%0d val=%0d want 1/7/30", reg_we, reg_id, reg_val);
        else n_pass++;
        for (int t = 0; t < 4; t++) begin
            lat = (t == 0) ? 0 : int'($urandom_range(1, 5));
            a_exp = $urandom;
            v_exp = $urandom;
            @(negedge clk_ex); mem_ready = 1'b0; drive(8'd9, 8'd3, 24'd0, 16'd0, a_exp, v_exp);
            @(negedge clk_ex); in_valid = 1'b0;
            for (int k = 0; k <= lat; k++) begin
                if (k > 0) @(negedge clk_ex);
                mem_ready = (k == lat);
                n_checks++;
                if ({mem_valid, mem_addr, mem_val} !== {1'b1, a_exp, v_exp})
                    $display("FAIL store_rand[%0d.%0d]: got mv=%b addr=%h val=%h want 1/%h/%h",
                             t, k, mem_valid, mem_addr, mem_val, a_exp, v_exp);
                else n_pass++;
            end
            @(negedge clk_ex); mem_ready = 1'b0;
            n_checks++;
            if ({mem_valid, in_ready} !== 2'b01)
                $display("FAIL store_rand_end[%0d]: got mv=%b rdy=%b want 0/1", t, mem_valid, in_ready);
            else n_pass++;
        end
    endtask

`ifdef EXEC_MUL_EN
    task automatic test_mul();
        int busy;
        bit done;
        logic [31:0] b;
        logic [31:0] c;
        exp_t e;
        for (int t = 0; t < 4; t++) begin
            b = (t == 0) ? 32'd123 : $urandom;
            c = (t == 0) ? 32'd1000 : ((t == 1) ? 32'd0 : $urandom);
            e = model(8'd14, 8'd3, 24'd0, 16'd0, b, c);
            @(negedge clk_ex); drive(8'd14, 8'd3, 24'd0, 16'd0, b, c);
            @(negedge clk_ex); drive(8'd12, 8'd9, 24'd0, 16'd0, 32'd1, 32'd2);
            busy = 0;
            done = 1'b0;
            for (int k = 0; k < 100 && !done; k++) begin
                if (k > 0) @(negedge clk_ex);
                if (reg_we) done = 1'b1;
                else if (!in_ready) busy++;
            end
            n_checks++;
            if (!done || busy != DATA_W / MUL_STEP || reg_id !== e.id || reg_val !== e.val || in_ready !== 1'b1)
                $display("FAIL mul[%0d]: got done=%b busy=%0d id=%0d val=%h want 1/%0d/%0d/%h",
                         t, done, busy, reg_id, reg_val, DATA_W / MUL_STEP, e.id, e.val);
            else n_pass++;
            @(negedge clk_ex); in_valid = 1'b0;
            n_checks++;
            if ({reg_we, reg_id, reg_val} !== {1'b1, 8'd9, 32'd3})
                $display("FAIL held_after_mul[%0d]: got we=%b id=%0d val=%0d want 1/9/3", t, reg_we, reg_id, reg_val);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        logic [5:0] legal [8];
        exp_t e;
        bit have;
        logic [7:0] op;
        logic [7:0] a;
        logic [23:0] b;
        logic [15:0] c;
        logic [31:0] sb;
        logic [31:0] sc;
        logic [76:0] got;
        logic [76:0] want;
        int mode;
        legal = '{6'd0, 6'd1, 6'd12, 6'd13, 6'd18, 6'd22, 6'd23, 6'd24};
        have = 1'b0;
        e = '0;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk_ex);
            if (have) begin
                got  = {reg_we, reg_id, reg_val, br_taken, br_off, illegal, mem_valid, in_ready};
                want = {e.we, e.id, e.val, e.br, e.off, e.ill, 1'b0, 1'b1};
                n_checks++;
                if (got !== want) $display("FAIL random[%0d] op=%h: got %h want %h", i, op, got, want);
                else n_pass++;
            end
            have = 1'b1;
            if (i == 300 || $urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                e = '0;
            end else begin
                if ($urandom_range(0, 9) < 8) begin
                    op = {2'($urandom), legal[int'($urandom_range(0, 7))]};
                end else begin
                    op = 8'($urandom);
                    while (op[5:0] == 6'd9) op = 8'($urandom);
`ifdef EXEC_MUL_EN
                    while (op[5:0] == 6'd9 || op[5:0] == 6'd14) op = 8'($urandom);
`endif
                end
                a = 8'($urandom);
                b = 24'($urandom);
                c = 16'($urandom);
                mode = int'($urandom_range(0, 3));
                sb = (mode == 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
                sc = (mode == 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
                if (mode == 1) sc = sb;
                e = model(op, a, b, c, sb, sc);
                drive(op, a, b, c, sb, sc);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        opecode   = 8'd0;
        operandA  = '0;
        operandB  = 24'd0;
        operandC  = 16'd0;
        src_b     = '0;
        src_c     = '0;
        mem_ready = 1'b0;
        test_reset();
        test_reset_midop();
        test_add_sub();
        test_branch();
        test_illegal();
        test_store();
`ifdef EXEC_MUL_EN
        test_mul();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
